conv_mem_host: RTL and testbench

- Memory-side responder for the convolution engine's image and layer-memory buses.
- Owns three memories: the 64x64 input image ROM image, layer-0 RAM (4096 words) and layer-1 RAM (1024 words).
- Answers engine iaddr reads and c* read/write cycles, generates the ready/busy start handshake, and gives a host port for preload and result readback.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_sdp_ram.sv | 38 +++
 rtl/conv_mem_host.sv | 199 +++++++++++++++++++
 tb/tb_conv_mem_host.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution engine memory host.
// Bus widths, memory-select encodings and the start-handshake state type.
package conv_pkg;

    localparam int unsigned DW = 20;
    localparam int unsigned AW = 12;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    localparam logic [1:0] HOST_IMG  = 2'd0;
    localparam logic [1:0] HOST_L0   = 2'd1;
    localparam logic [1:0] HOST_L1   = 2'd2;
    localparam logic [1:0] HOST_NONE = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StWaitHi,
        StRun,
        StDone
    } conv_state_e;

endpackage

// File: rtl/conv_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-cycle read and write of one address returns the old word.
module conv_sdp_ram #(
    parameter int unsigned Depth = 4096,
    parameter int unsigned Width = 20,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic             re,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] rdata_q;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/conv_mem_host.sv
// Memory-side responder for the convolution engine: image ROM, layer-0/1 RAMs,
// the ready/busy start handshake, and a host port for preload and readback.
module conv_mem_host
    import conv_pkg::*;
#(
    parameter int unsigned L1_DEPTH    = 1024,
    parameter int unsigned BUSY_WAIT   = 16,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    input  logic          start,
    input  logic          host_we,
    input  logic          host_re,
    input  logic [1:0]    host_sel,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          done,
    output logic          err
);

    localparam int unsigned CntW     = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned L1W      = $clog2(L1_DEPTH);
    localparam int unsigned ImgDepth = 1 << AW;

    conv_state_e     state_q, state_d;
    logic            ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic host_ok;
    logic l1_wr_ok, l1_rd_ok, l1_host_ok;
    logic eng_w0, eng_w1, host_w0, host_w1, host_wi;
    logic eng_r0, eng_r1, host_r0, host_r1;
    logic [DW-1:0] l0_rdata, l1_rdata;

    logic          eng_rd_q;
    logic [1:0]    eng_src_q, eng_src_d, host_src_q, host_src_d;
    logic          host_rvalid_q;
    logic [DW-1:0] cdata_hold_q;

    assign host_ok    = (state_q == StIdle) || (state_q == StDone);
    assign l1_wr_ok   = 32'(caddr_wr) < L1_DEPTH;
    assign l1_rd_ok   = 32'(caddr_rd) < L1_DEPTH;
    assign l1_host_ok = 32'(host_addr) < L1_DEPTH;

    assign eng_w0  = cwr && (csel == CSEL_L0);
    assign eng_w1  = cwr && (csel == CSEL_L1) && l1_wr_ok;
    assign host_wi = host_ok && host_we && (host_sel == HOST_IMG);
    assign host_w0 = host_ok && host_we && (host_sel == HOST_L0) && !eng_w0;
    assign host_w1 = host_ok && host_we && (host_sel == HOST_L1) && l1_host_ok && !eng_w1;

    // Engine owns each read port; the host only gets a port the engine leaves idle.
    assign eng_r0  = crd && (csel == CSEL_L0);
    assign eng_r1  = crd && (csel == CSEL_L1) && l1_rd_ok;
    assign host_r0 = host_ok && host_re && (host_sel == HOST_L0) && !eng_r0;
    assign host_r1 = host_ok && host_re && (host_sel == HOST_L1) && l1_host_ok && !eng_r1;

    conv_sdp_ram #(.Depth(ImgDepth), .Width(DW)) u_img (
        .clk   (clk),
        .reset (reset),
        .we    (host_wi),
        .waddr (host_addr),
        .wdata (host_wdata),
        .re    (1'b1),
        .raddr (iaddr),
        .rdata (idata)
    );

    conv_sdp_ram #(.Depth(ImgDepth), .Width(DW)) u_l0 (
        .clk   (clk),
        .reset (reset),
        .we    (eng_w0 || host_w0),
        .waddr (eng_w0 ? caddr_wr : host_addr),
        .wdata (eng_w0 ? cdata_wr : host_wdata),
        .re    (eng_r0 || host_r0),
        .raddr (eng_r0 ? caddr_rd : host_addr),
        .rdata (l0_rdata)
    );

    conv_sdp_ram #(.Depth(L1_DEPTH), .Width(DW)) u_l1 (
        .clk   (clk),
        .reset (reset),
        .we    (eng_w1 || host_w1),
        .waddr (eng_w1 ? caddr_wr[L1W-1:0] : host_addr[L1W-1:0]),
        .wdata (eng_w1 ? cdata_wr : host_wdata),
        .re    (eng_r1 || host_r1),
        .raddr (eng_r1 ? caddr_rd[L1W-1:0] : host_addr[L1W-1:0]),
        .rdata (l1_rdata)
    );

    // Image port is dedicated to iaddr, so host image reads return 0.
    always_comb begin
        eng_src_d  = eng_r0 ? HOST_L0 : (eng_r1 ? HOST_L1 : HOST_NONE);
        host_src_d = host_r0 ? HOST_L0 : (host_r1 ? HOST_L1 : HOST_NONE);
    end

    always_comb begin
        cdata_rd = cdata_hold_q;
        if (eng_rd_q) begin
            unique case (eng_src_q)
                HOST_L0: cdata_rd = l0_rdata;
                HOST_L1: cdata_rd = l1_rdata;
                default: cdata_rd = '0;
            endcase
        end
        host_rdata = '0;
        if (host_rvalid_q) begin
            unique case (host_src_q)
                HOST_L0: host_rdata = l0_rdata;
                HOST_L1: host_rdata = l1_rdata;
                default: host_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eng_rd_q      <= 1'b0;
            eng_src_q     <= HOST_NONE;
            host_src_q    <= HOST_NONE;
            host_rvalid_q <= 1'b0;
            cdata_hold_q  <= '0;
        end else begin
            eng_rd_q      <= crd;
            eng_src_q     <= eng_src_d;
            host_src_q    <= host_src_d;
            host_rvalid_q <= host_re;
            cdata_hold_q  <= cdata_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        err_d   = err_q || (!host_ok && (host_we || host_re));
        unique case (state_q)
            StIdle:   if (start) state_d = StPulse;
            StPulse:  state_d = StWaitHi;
            StWaitHi: begin
                if (busy) begin
                    state_d = StRun;
                end else if (cnt_q >= CntW'(BUSY_WAIT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StRun: begin
                if (!busy) begin
                    state_d = StDone;
                end else if (cnt_q >= CntW'(TIMEOUT_CYC - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end
            end
            StDone:   if (start) state_d = StPulse;
            default:  state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        ready_d = (state_d == StPulse);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Scoreboard bench for conv_mem_host: read results are queued when requested
// and checked by negedge monitors; handshake/status checks sit in each task.
module tb_conv_mem_host;
    import conv_pkg::*;

    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          reset, busy, cwr, crd, start, host_we, host_re;
    logic [11:0]   iaddr, caddr_wr, caddr_rd, host_addr;
    logic [19:0]   cdata_wr, host_wdata;
    logic [2:0]    csel;
    logic [1:0]    host_sel;
    logic          ready, done, err, host_rvalid;
    logic [19:0]   idata, cdata_rd, host_rdata;

    int total = 0;
    int bad   = 0;
    logic [19:0] host_q[$];
    logic [19:0] eng_q[$];
    logic        crd_seen;
    logic [19:0] exp_h, exp_e;

    conv_mem_host #(.L1_DEPTH(1024), .BUSY_WAIT(BW), .TIMEOUT_CYC(2000000)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .start(start), .host_we(host_we), .host_re(host_re), .host_sel(host_sel),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) crd_seen <= crd & ~reset;

    always @(negedge clk) begin
        if (host_rvalid === 1'b1) begin
            total++;
            if (host_q.size() == 0) begin
                bad++;
                $display("FAIL host_rvalid_unexpected got rdata=%h want no pulse", host_rdata);
            end else begin
                exp_h = host_q.pop_front();
                if (host_rdata !== exp_h) begin
                    bad++;
                    $display("FAIL host_rdata got=%h want=%h", host_rdata, exp_h);
                end
            end
        end
        if (crd_seen === 1'b1) begin
            total++;
            if (eng_q.size() == 0) begin
                bad++;
                $display("FAIL cdata_rd_unexpected got=%h want no read", cdata_rd);
            end else begin
                exp_e = eng_q.pop_front();
                if (cdata_rd !== exp_e) begin
                    bad++;
                    $display("FAIL cdata_rd got=%h want=%h", cdata_rd, exp_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        busy = 0; cwr = 0; crd = 0; start = 0; host_we = 0; host_re = 0;
        iaddr = 0; caddr_wr = 0; caddr_rd = 0; host_addr = 0;
        cdata_wr = 0; host_wdata = 0; csel = 0; host_sel = HOST_NONE;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", host_rvalid); end
        total++; if (idata !== 20'h0) begin bad++; $display("FAIL reset_idata got=%h want=0", idata); end
        total++; if (cdata_rd !== 20'h0) begin bad++; $display("FAIL reset_cdata_rd got=%h want=0", cdata_rd); end
        total++; if (host_rdata !== 20'h0) begin bad++; $display("FAIL reset_host_rdata got=%h want=0", host_rdata); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_preload();
        logic [1:0]  sels  [5] = '{HOST_IMG, HOST_IMG, HOST_L0, HOST_L0, HOST_L1};
        logic [11:0] addrs [5] = '{12'h000, 12'hFFF, 12'h007, 12'h009, 12'h000};
        logic [19:0] datas [5] = '{20'h00010, 20'hFFFF0, 20'h00001, 20'h00009, 20'h00777};
        for (int i = 0; i < 5; i++) begin
            host_we = 1; host_sel = sels[i]; host_addr = addrs[i]; host_wdata = datas[i];
            @(negedge clk);
        end
        host_we = 0;
        host_re = 1; host_sel = HOST_L0; host_addr = 12'h007; host_q.push_back(20'h00001);
        iaddr = 12'hFFF;
        @(negedge clk);
        host_re = 0;
        total++; if (idata !== 20'hFFFF0) begin bad++; $display("FAIL idata_fff got=%h want=FFFF0", idata); end
        iaddr = 12'h000;
        @(negedge clk);
        total++; if (idata !== 20'h00010) begin bad++; $display("FAIL idata_000 got=%h want=00010", idata); end
    endtask

    task automatic test_run();
        int rc = 0;
        int n = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready === 1'b1) rc++;
            if (i == 2) busy = 1;
            @(negedge clk);
        end
        total++; if (rc != 1) begin bad++; $display("FAIL ready_width got=%0d want=1", rc); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_while_run got=%b want=0", done); end
        cwr = 1; csel = CSEL_L0; caddr_wr = 12'h005; cdata_wr = 20'h12345;
        @(negedge clk);
        csel = CSEL_L1; caddr_wr = 12'h3FF; cdata_wr = 20'h0ABCD;
        @(negedge clk);
        cwr = 0; busy = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL run_done got=%b want=1", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL run_err got=%b want=0", err); end
        host_re = 1; host_sel = HOST_L0; host_addr = 12'h005; host_q.push_back(20'h12345);
        @(negedge clk);
        host_sel = HOST_L1; host_addr = 12'h3FF; host_q.push_back(20'h0ABCD);
        @(negedge clk);
        host_re = 0;
        @(negedge clk);
        @(negedge clk);
        total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%b want=0", host_rvalid); end
    endtask

    task automatic test_back_to_back_rbw();
        csel = CSEL_L0; cwr = 1; crd = 1; caddr_wr = 12'h007; caddr_rd = 12'h007;
        cdata_wr = 20'h00002; eng_q.push_back(20'h00001);
        @(negedge clk);
        cwr = 0; eng_q.push_back(20'h00002);
        @(negedge clk);
        crd = 0;
        @(negedge clk);
        total++; if (cdata_rd !== 20'h00002) begin bad++; $display("FAIL cdata_hold got=%h want=00002", cdata_rd); end
    endtask

    task automatic test_unmapped();
        csel = CSEL_L1; cwr = 1; caddr_wr = 12'h400; cdata_wr = 20'h55555;
        @(negedge clk);
        cwr = 0; crd = 1; caddr_rd = 12'h400; eng_q.push_back(20'h0);
        @(negedge clk);
        caddr_rd = 12'h000; eng_q.push_back(20'h00777);
        @(negedge clk);
        csel = 3'b010; caddr_rd = 12'h005; eng_q.push_back(20'h0);
        @(negedge clk);
        crd = 0; csel = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_busy_never();
        int n = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL restart_ready got=%b want=1", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL restart_done_clear got=%b want=0", done); end
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++; if (n != BW + 1) begin bad++; $display("FAIL busy_wait_cycles got=%0d want=%0d", n, BW + 1); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL busy_wait_err got=%b want=1", err); end
    endtask

    task automatic test_mid_run_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", err); end
        start = 1;
        @(negedge clk);
        start = 0; busy = 1;
        @(negedge clk);
        @(negedge clk);
        host_we = 1; host_sel = HOST_L0; host_addr = 12'h009; host_wdata = 20'h99999;
        @(negedge clk);
        host_we = 0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL host_wr_run_err got=%b want=1", err); end
        host_re = 1; host_q.push_back(20'h0);
        @(negedge clk);
        host_re = 0;
        @(negedge clk);
        reset = 1; busy = 0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b want=0", ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
        reset = 0;
        host_re = 1; host_sel = HOST_L0; host_addr = 12'h009; host_q.push_back(20'h00009);
        @(negedge clk);
        host_addr = 12'h005; host_q.push_back(20'h12345);
        @(negedge clk);
        host_re = 0;
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL idle_read_err got=%b want=0", err); end
        start = 1;
        @(negedge clk);
        start = 0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL post_reset_start got=%b want=1", ready); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_run();
        test_back_to_back_rbw();
        test_unmapped();
        test_busy_never();
        test_mid_run_reset();
        total++; if (host_q.size() != 0) begin bad++; $display("FAIL host_q_left got=%0d want=0", host_q.size()); end
        total++; if (eng_q.size() != 0) begin bad++; $display("FAIL eng_q_left got=%0d want=0", eng_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
